// File: rtl/deal_sequencer_if.sv
// rtl/deal_sequencer_if.sv - handshake between the deal sequencer and the single-card drawer
interface deal_sequencer_if #(
    parameter int NUM_CARDS = 106,
    parameter int IDX_W     = 7
);
    logic                 draw_one;
    logic                 drawer_ready;
    logic                 drawer_done;
    logic [IDX_W-1:0]     drawn_idx;
    logic [NUM_CARDS-1:0] available_card;

    modport master (
        output draw_one, available_card,
        input  drawer_ready, drawer_done, drawn_idx
    );

    modport slave (
        input  draw_one, available_card,
        output drawer_ready, drawer_done, drawn_idx
    );
endinterface

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - owns the deck mask and deals N cards to one hand via the drawer
module deal_sequencer #(
    parameter int NUM_CARDS = 106,
    parameter int IDX_W     = 7,
    parameter int CNT_W     = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 deck_init,
    input  logic                 deal_start,
    input  logic [CNT_W-1:0]     deal_count,
    input  logic                 deal_player,
    deal_sequencer_if.master     drw,
    output logic [NUM_CARDS-1:0] hand0,
    output logic [NUM_CARDS-1:0] hand1,
    output logic [IDX_W-1:0]     cards_left,
    output logic                 busy,
    output logic                 deal_done,
    output logic                 deal_short,
    output logic                 deal_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] FULL_COUNT = IDX_W'(NUM_CARDS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, FIN} state_t;

    state_t               state, state_nxt;
    logic [NUM_CARDS-1:0] avail;
    logic [CNT_W-1:0]     remaining;
    logic                 player;
    logic [IDX_W-1:0]     idx_q;
    logic [WD_W-1:0]      wd;
    logic                 idx_bad, timed_out, start_empty;

    assign drw.available_card = avail;
    assign busy        = (state != IDLE);
    assign idx_bad     = (int'(idx_q) >= NUM_CARDS) || !avail[idx_q];
    assign timed_out   = !drw.drawer_done && (wd == WD_W'(TIMEOUT - 1));
    // a same-cycle deck_init refills the deck before the deal looks at it
    assign start_empty = (cards_left == '0) && !deck_init;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        drw.draw_one = 1'b0;
        deal_done    = 1'b0;
        case (state)
            IDLE: begin
                if (deal_start)
                    state_nxt = (deal_count == '0 || start_empty) ? FIN : ISSUE;
            end
            ISSUE: begin
                if (drw.drawer_ready) begin
                    drw.draw_one = 1'b1;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (drw.drawer_done) state_nxt = COMMIT;
                else if (timed_out)  state_nxt = FIN;
            end
            COMMIT: begin
                if (idx_bad)                             state_nxt = ISSUE;
                else if (remaining == CNT_W'(1))         state_nxt = FIN;
                else if (cards_left == IDX_W'(1))        state_nxt = FIN;
                else                                     state_nxt = ISSUE;
            end
            FIN: begin
                deal_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avail      <= '1;
            hand0      <= '0;
            hand1      <= '0;
            cards_left <= FULL_COUNT;
            remaining  <= '0;
            player     <= 1'b0;
            idx_q      <= '0;
            wd         <= '0;
            deal_short <= 1'b0;
            deal_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (deck_init) begin
                        avail      <= '1;
                        hand0      <= '0;
                        hand1      <= '0;
                        cards_left <= FULL_COUNT;
                        deal_err   <= 1'b0;
                    end
                    if (deal_start) begin
                        remaining  <= deal_count;
                        player     <= deal_player;
                        deal_err   <= 1'b0;
                        deal_short <= (deal_count != '0) && start_empty;
                    end
                end
                ISSUE: begin
                    if (drw.drawer_ready) wd <= '0;
                end
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (drw.drawer_done) idx_q <= drw.drawn_idx;
                    if (timed_out)       deal_err <= 1'b1;
                end
                COMMIT: begin
                    if (idx_bad) begin
                        deal_err <= 1'b1;
                    end else begin
                        avail[idx_q] <= 1'b0;
                        if (player) hand1[idx_q] <= 1'b1;
                        else        hand0[idx_q] <= 1'b1;
                        cards_left <= cards_left - IDX_W'(1);
                        remaining  <= remaining - CNT_W'(1);
                        if (remaining != CNT_W'(1) && cards_left == IDX_W'(1))
                            deal_short <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
